// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
// SYS_CLK_HZ lets higher layers turn a cycle count into a frequency.
package clk_meas_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  localparam int          DEFAULT_CNT_W       = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 100_000_000;
  localparam int unsigned SYS_CLK_HZ          = 100_000_000;

endpackage

// File: rtl/clock_period_meter_if.sv
// Control and result bundle of the clock period meter.
// The meter itself connects through the slave modport.
interface clock_period_meter_if
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output en,
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  en,
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output timeout,
    output busy
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus a history flop,
// giving single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow input in clk cycles between rising
// edges, reporting a timeout when the input stops toggling.
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  meas_state_t      state;
  meas_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] high_cap;
  logic [CNT_W-1:0] high_cap_next;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] high_time_next;
  logic             meas_valid_q;
  logic             meas_valid_next;
  logic             timeout_q;
  logic             timeout_next;
  logic             busy_q;
  logic             rise;
  logic             fall;
  logic             level_unused;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (bus.sig_in),
    .level  (level_unused),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A rise on the cycle the counter reaches the limit still counts as a
  // valid measurement; the timeout only fires when no edge arrived in time.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    high_cap_next   = high_cap;
    period_next     = period_q;
    high_time_next  = high_time_q;
    meas_valid_next = 1'b0;
    timeout_next    = 1'b0;

    if (!bus.en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_next = '0;
          if (rise) begin
            cnt_next   = CNT_ONE;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next     = cnt;
            high_time_next  = high_cap;
            meas_valid_next = 1'b1;
            cnt_next        = CNT_ONE;
          end else if (cnt == TIMEOUT_VAL) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = IDLE;
          end else begin
            cnt_next = cnt + CNT_ONE;
            if (fall) begin
              high_cap_next = cnt;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      high_cap     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      high_cap     <= high_cap_next;
      period_q     <= period_next;
      high_time_q  <= high_time_next;
      meas_valid_q <= meas_valid_next;
      timeout_q    <= timeout_next;
      busy_q       <= (state_next == MEASURE);
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: an edge-timestamp model checks every
// cycle, and literal expectations pin the key measurements.
module tb_clock_period_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Holds sig_in/en for n clk edges; always called and returns at a negedge.
  task automatic applyStimulus(input logic s, input logic e, input int n);
    bus.sig_in = s;
    bus.en     = e;
    repeat (n) @(negedge clk);
  endtask

  // Model: timestamps of synchronised edges, measured in clk edges.
  int m_edge, m_t0, m_fall;
  bit m_armed, m_p1, m_p2, m_p3, m_rise, m_fallev;
  int exp_period, exp_high;
  bit exp_valid, exp_timeout;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_edge = 0; m_t0 = 0; m_fall = 0; m_armed = 0;
      m_p1 = 0; m_p2 = 0; m_p3 = 0;
      exp_period = 0; exp_high = 0; exp_valid = 0; exp_timeout = 0;
    end else begin
      m_edge++;
      m_rise   = m_p2 & ~m_p3;
      m_fallev = ~m_p2 & m_p3;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = bus.sig_in;
      exp_valid   = 0;
      exp_timeout = 0;
      if (!bus.en) begin
        m_armed = 0;
      end else if (!m_armed) begin
        if (m_rise) begin
          m_armed = 1;
          m_t0    = m_edge;
        end
      end else if (m_rise) begin
        exp_period = m_edge - m_t0;
        exp_high   = m_fall - m_t0;
        exp_valid  = 1;
        m_t0       = m_edge;
      end else if (m_edge - m_t0 == TIMEOUT) begin
        exp_timeout = 1;
        m_armed     = 0;
      end else if (m_fallev) begin
        m_fall = m_edge;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("period",     bus.period,              32'(exp_period));
      checkOutput("high_time",  bus.high_time,           32'(exp_high));
      checkOutput("meas_valid", 32'(bus.meas_valid),     32'(exp_valid));
      checkOutput("timeout",    32'(bus.timeout),        32'(exp_timeout));
      checkOutput("busy",       32'(bus.busy),           32'(m_armed));
    end
  end

  int cyc = 0;
  int valid_count = 0, timeout_count = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0, last_timeout_cyc = 0, busy_rise_cyc = 0;
  bit busy_d = 0;

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.meas_valid) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      valid_count++;
    end
    if (bus.timeout) begin
      last_timeout_cyc = cyc;
      timeout_count++;
    end
    if (bus.busy && !busy_d) busy_rise_cyc = cyc;
    busy_d = bus.busy;
  end

  int v0, t0c;

  initial begin
    rst_n      = 1'b0;
    bus.sig_in = 1'b0;
    bus.en     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_period",     bus.period,          32'd0);
    checkOutput("rst_high_time",  bus.high_time,       32'd0);
    checkOutput("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
    checkOutput("rst_timeout",    32'(bus.timeout),    32'd0);
    checkOutput("rst_busy",       32'(bus.busy),       32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Toggle every 2 cycles: 6 rises, first only arms.
    v0 = valid_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b1, 1'b1, 2);
    end
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("div1_period", bus.period,               32'd4);
    checkOutput("div1_high",   bus.high_time,            32'd2);
    checkOutput("div1_count",  32'(valid_count - v0),    32'd5);
    if (bus.period != 0)
      $display("[TB] div1 frequency %0d Hz", SYS_CLK_HZ / bus.period);

    // Toggle every 5 cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 5);
      applyStimulus(1'b1, 1'b1, 5);
    end
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("div4_period",  bus.period,                            32'd10);
    checkOutput("div4_high",    bus.high_time,                         32'd5);
    checkOutput("div4_spacing", 32'(last_valid_cyc - prev_valid_cyc),  32'd10);

    // Single rise then held high: timeout after TIMEOUT cycles.
    applyStimulus(1'b0, 1'b0, 2);
    t0c = timeout_count;
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 30);
    checkOutput("to_count",   32'(timeout_count - t0c),             32'd1);
    checkOutput("to_delay",   32'(last_timeout_cyc - busy_rise_cyc), 32'd20);
    checkOutput("to_busy",    32'(bus.busy),                        32'd0);
    checkOutput("to_period",  bus.period,                           32'd10);

    // Rise spacing exactly TIMEOUT: valid wins over timeout.
    v0  = valid_count;
    t0c = timeout_count;
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("edge_valid",   32'(valid_count - v0),    32'd1);
    checkOutput("edge_timeout", 32'(timeout_count - t0c), 32'd0);
    checkOutput("edge_period",  bus.period,               32'd20);
    checkOutput("edge_high",    bus.high_time,            32'd10);

    // Enable dropped for 3 cycles mid-period, then re-armed.
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("en_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 2);
    v0 = valid_count;
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("en_rearm", 32'(valid_count - v0), 32'd0);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("en_valid",  32'(valid_count - v0), 32'd1);
    checkOutput("en_period", bus.period,            32'd8);
    checkOutput("en_high",   bus.high_time,         32'd4);

    // Asynchronous reset mid-measurement with cnt at 7.
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_period", bus.period,          32'd0);
    checkOutput("arst_high",   bus.high_time,       32'd0);
    checkOutput("arst_busy",   32'(bus.busy),       32'd0);
    checkOutput("arst_valid",  32'(bus.meas_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("post_rst_period", bus.period,    32'd6);
    checkOutput("post_rst_high",   bus.high_time, 32'd3);
    applyStimulus(1'b0, 1'b0, 3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
